mem_stage_sram: RTL and testbench

Memory stage of the five-stage pipeline, sitting between the EX/MEM pipeline register and `MEM_Stage_reg`. It performs 32-bit loads and stores against an external 16-bit asynchronous SRAM as two half-word accesses, sequenced by a wait-state FSM. While an access is in progress it asserts `freeze` to hold the upstream pipeline and injects a bubble into `MEM_Stage_reg`.

---
 rtl/mem_stage_sram.sv | 214 +++++++++++++++++++++
 tb/tb_mem_stage_sram.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_sram.sv
// -----------------------------------------------------------------------------
// mem_stage_sram
//   Memory stage of the five-stage pipeline. A 32-bit load/store is split into
//   two half-word accesses to an external 16-bit asynchronous SRAM, each phase
//   lasting SRAM_WAIT cycles. While an access runs, `freeze` stalls the
//   upstream pipeline and WB_en is forced low so MEM_Stage_reg sees a bubble.
//
// Parameters
//   SRAM_WAIT  cycles per half-word phase (>= 2)
//   BASE_ADDR  byte address mapping to SRAM word 0
//
// Ports
//   clk, rst                      clock (rising), synchronous active-low reset
//   WB_en_in, MEM_R_EN_in,
//   MEM_W_EN_in, ALU_result_in,
//   ST_val_in, Dest_in, PC_in     EX/MEM inputs
//   WB_en                         WB_en_in gated by freeze and reset
//   MEM_R_EN, ALU_result, Dest,
//   PC                            combinational pass-through
//   MEM_read_value                load-data register
//   freeze                        stall request to the upstream stages
//   sram_addr, sram_dq_out,
//   sram_dq_oe, sram_we_n         registered SRAM controls
//   sram_dq_in                    SRAM read data
//
// Optional feature
//   MEM_STAGE_READ_CACHE_EN : one-entry read tag; a repeated read of the last
//   completed word index finishes in IDLE without touching the SRAM.
// -----------------------------------------------------------------------------
module mem_stage_sram #(
    parameter int unsigned SRAM_WAIT = 2,
    parameter int unsigned BASE_ADDR = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        WB_en_in,
    input  logic        MEM_R_EN_in,
    input  logic        MEM_W_EN_in,
    input  logic [31:0] ALU_result_in,
    input  logic [31:0] ST_val_in,
    input  logic [4:0]  Dest_in,
    input  logic [31:0] PC_in,
    output logic        WB_en,
    output logic        MEM_R_EN,
    output logic [31:0] ALU_result,
    output logic [4:0]  Dest,
    output logic [31:0] PC,
    output logic [31:0] MEM_read_value,
    output logic        freeze,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_we_n
);

    localparam int             CW   = $clog2(SRAM_WAIT);
    localparam logic [CW-1:0]  LAST = CW'(SRAM_WAIT - 1);
    localparam logic [31:0]    BASE = 32'(BASE_ADDR);

    typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    rd_val_q, rd_val_d;
    logic [17:0]    addr_q, addr_d;
    logic [15:0]    dq_out_q, dq_out_d;
    logic           dq_oe_q, dq_oe_d;
    logic           we_n_q, we_n_d;
    logic           freeze_c;
    logic           hit;

    // Word index of (ALU_result_in - BASE) >> 2, bits [16:0]. Only address
    // bits [18:0] influence those result bits; bits [1:0] only contribute the
    // borrow into bit 2.
    logic        borrow;
    logic [16:0] idx;
    assign borrow = (ALU_result_in[1:0] < BASE[1:0]);
    assign idx    = ALU_result_in[18:2] - BASE[18:2] - {16'b0, borrow};

    logic req, wr_req;
    assign req    = MEM_R_EN_in | MEM_W_EN_in;
    // Read wins when both enables are set.
    assign wr_req = MEM_W_EN_in & ~MEM_R_EN_in;

`ifdef MEM_STAGE_READ_CACHE_EN
    logic        valid_q, valid_d;
    logic [16:0] tag_q, tag_d;

    assign hit = (state_q == S_IDLE) & MEM_R_EN_in & valid_q & (idx == tag_q);

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        if (state_q == S_IDLE && wr_req) begin
            valid_d = 1'b0;
        end
        if (state_q == S_DONE && MEM_R_EN_in) begin
            valid_d = 1'b1;
            tag_d   = idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
        end
    end
`else
    assign hit = 1'b0;
`endif

    // Next state, phase counter and freeze.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        freeze_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req && !hit) begin
                    freeze_c = 1'b1;
                    state_d  = S_LO;
                    cnt_d    = '0;
                end
            end
            S_LO: begin
                freeze_c = 1'b1;
                if (cnt_q == LAST) begin
                    state_d = S_HI;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HI: begin
                freeze_c = 1'b1;
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                // DONE: inputs still show this instruction; never retrigger.
                state_d = S_IDLE;
            end
        endcase
    end

    // SRAM controls are registered, so they are derived from the state and
    // counter of the *next* cycle; they then line up with the phase itself.
    always_comb begin
        addr_d   = addr_q;
        dq_out_d = dq_out_q;
        dq_oe_d  = 1'b0;
        we_n_d   = 1'b1;
        if (state_d == S_LO || state_d == S_HI) begin
            addr_d = {idx, (state_d == S_HI)};
            if (wr_req) begin
                dq_oe_d  = 1'b1;
                we_n_d   = (cnt_d == LAST);  // strobe released on last cycle
                dq_out_d = (state_d == S_HI) ? ST_val_in[31:16] : ST_val_in[15:0];
            end
        end
    end

    // Load data is sampled on the last cycle of each phase, when the address
    // has been stable for the whole phase.
    always_comb begin
        rd_val_d = rd_val_q;
        if (!wr_req && cnt_q == LAST) begin
            if (state_q == S_LO) rd_val_d[15:0]  = sram_dq_in;
            if (state_q == S_HI) rd_val_d[31:16] = sram_dq_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rd_val_q <= '0;
            addr_q   <= '0;
            dq_out_q <= '0;
            dq_oe_q  <= 1'b0;
            we_n_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_val_q <= rd_val_d;
            addr_q   <= addr_d;
            dq_out_q <= dq_out_d;
            dq_oe_q  <= dq_oe_d;
            we_n_q   <= we_n_d;
        end
    end

    assign freeze         = freeze_c & rst;
    assign WB_en          = WB_en_in & ~freeze & rst;
    assign MEM_R_EN       = MEM_R_EN_in;
    assign ALU_result     = ALU_result_in;
    assign Dest           = Dest_in;
    assign PC             = PC_in;
    assign MEM_read_value = rd_val_q;
    assign sram_addr      = addr_q;
    assign sram_dq_out    = dq_out_q;
    assign sram_dq_oe     = dq_oe_q;
    assign sram_we_n      = we_n_q;

endmodule

// File: tb/tb_mem_stage_sram.sv
module tb_mem_stage_sram;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        WB_en_in, MEM_R_EN_in, MEM_W_EN_in;
    logic [31:0] ALU_result_in, ST_val_in, PC_in;
    logic [4:0]  Dest_in;
    logic        WB_en, MEM_R_EN, freeze;
    logic [31:0] ALU_result, PC, MEM_read_value;
    logic [4:0]  Dest;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_we_n;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_stage_sram #(.SRAM_WAIT(W), .BASE_ADDR(1024)) dut (
        .clk(clk), .rst(rst),
        .WB_en_in(WB_en_in), .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in),
        .ALU_result_in(ALU_result_in), .ST_val_in(ST_val_in),
        .Dest_in(Dest_in), .PC_in(PC_in),
        .WB_en(WB_en), .MEM_R_EN(MEM_R_EN), .ALU_result(ALU_result),
        .Dest(Dest), .PC(PC), .MEM_read_value(MEM_read_value),
        .freeze(freeze), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
        .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
    );

    // Asynchronous SRAM model, 512 half-words; out-of-range reads return 0.
    logic [15:0] mem [0:511];
    always @(posedge clk)
        if (!sram_we_n && sram_dq_oe && sram_addr < 18'd512)
            mem[sram_addr[8:0]] <= sram_dq_out;
    assign sram_dq_in = (sram_addr < 18'd512) ? mem[sram_addr[8:0]] : 16'h0000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic wb, input logic r, input logic w,
                          input logic [31:0] alu, input logic [31:0] st);
        WB_en_in = wb; MEM_R_EN_in = r; MEM_W_EN_in = w;
        ALU_result_in = alu; ST_val_in = st;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Checks one full memory access starting in IDLE in the current cycle,
    // and leaves time just after the edge that ends the DONE cycle.
    task automatic run_mem(input string tag, input bit wr, input logic [17:0] lo,
                           input logic [31:0] exp_rv);
        bit hi;
        int k;
        for (int c = 0; c <= 2*W+1; c++) begin
            @(negedge clk);
            hi = (c > W);
            k  = (c - 1) % W;
            if (c == 0) begin
                chk({tag, ".c0.freeze"}, 32'(freeze), 32'd1);
                chk({tag, ".c0.wb"},     32'(WB_en),  32'd0);
                chk({tag, ".c0.we_n"},   32'(sram_we_n), 32'd1);
            end else if (c <= 2*W) begin
                chk($sformatf("%s.c%0d.freeze", tag, c), 32'(freeze), 32'd1);
                chk($sformatf("%s.c%0d.wb", tag, c),     32'(WB_en),  32'd0);
                chk($sformatf("%s.c%0d.addr", tag, c),   32'(sram_addr), 32'(lo | 18'(hi)));
                chk($sformatf("%s.c%0d.we_n", tag, c),   32'(sram_we_n),
                    (wr && k != W-1) ? 32'd0 : 32'd1);
                chk($sformatf("%s.c%0d.oe", tag, c),     32'(sram_dq_oe), 32'(wr));
                if (wr)
                    chk($sformatf("%s.c%0d.dq", tag, c), 32'(sram_dq_out),
                        hi ? 32'(ST_val_in[31:16]) : 32'(ST_val_in[15:0]));
            end else begin
                chk({tag, ".done.freeze"}, 32'(freeze), 32'd0);
                chk({tag, ".done.wb"},     32'(WB_en),  32'(WB_en_in));
                chk({tag, ".done.addr"},   32'(sram_addr), 32'(lo | 18'd1));
                chk({tag, ".done.we_n"},   32'(sram_we_n), 32'd1);
                chk({tag, ".done.oe"},     32'(sram_dq_oe), 32'd0);
                chk({tag, ".done.rv"},     MEM_read_value, exp_rv);
            end
            step();
        end
    endtask

    initial begin
        rst = 1'b0;
        Dest_in = 5'd9; PC_in = 32'h0000_0040;
        set_in(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        step(); step();

        // Reset state
        @(negedge clk);
        chk("rst.wb",     32'(WB_en), 32'd0);
        chk("rst.freeze", 32'(freeze), 32'd0);
        chk("rst.we_n",   32'(sram_we_n), 32'd1);
        chk("rst.oe",     32'(sram_dq_oe), 32'd0);
        chk("rst.addr",   32'(sram_addr), 32'd0);
        chk("rst.dq",     32'(sram_dq_out), 32'd0);
        chk("rst.rv",     MEM_read_value, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // ALU op: no stall, pass-through, no SRAM activity
        set_in(1'b1, 1'b0, 1'b0, 32'd7, 32'd0);
        @(negedge clk);
        chk("alu.freeze", 32'(freeze), 32'd0);
        chk("alu.wb",     32'(WB_en), 32'd1);
        chk("alu.res",    ALU_result, 32'd7);
        chk("alu.dest",   32'(Dest), 32'd9);
        chk("alu.pc",     PC, 32'h0000_0040);
        chk("alu.we_n",   32'(sram_we_n), 32'd1);
        chk("alu.oe",     32'(sram_dq_oe), 32'd0);
        chk("alu.addr",   32'(sram_addr), 32'd0);
        step();

        // Store 0x12345678 to 1032 -> idx 2 -> half-words 4,5
        set_in(1'b0, 1'b0, 1'b1, 32'd1032, 32'h1234_5678);
        run_mem("st1032", 1'b1, 18'd4, 32'd0);
        chk("st1032.mem4", 32'(mem[4]), 32'h5678);
        chk("st1032.mem5", 32'(mem[5]), 32'h1234);

        // Load 1032 back-to-back
        set_in(1'b1, 1'b1, 1'b0, 32'd1032, 32'd0);
        run_mem("ld1032", 1'b0, 18'd4, 32'h1234_5678);

        // Store 0xDEADBEEF to 1028 -> half-words 2,3; load data untouched
        set_in(1'b0, 1'b0, 1'b1, 32'd1028, 32'hDEAD_BEEF);
        run_mem("st1028", 1'b1, 18'd2, 32'h1234_5678);
        chk("st1028.mem2", 32'(mem[2]), 32'hBEEF);
        chk("st1028.mem3", 32'(mem[3]), 32'hDEAD);

        // Load 1028
        set_in(1'b1, 1'b1, 1'b0, 32'd1028, 32'd0);
        run_mem("ld1028", 1'b0, 18'd2, 32'hDEAD_BEEF);

        // Address below BASE wraps: (1020-1024)>>2 -> idx 0x1FFFF
        set_in(1'b1, 1'b1, 1'b0, 32'd1020, 32'd0);
        run_mem("ldwrap", 1'b0, 18'h3FFFE, 32'd0);

        // Reset during the HI phase of a load from 1032
        set_in(1'b1, 1'b1, 1'b0, 32'd1032, 32'd0);
        step(); step(); step();
        @(negedge clk);
        chk("rsthi.addr",   32'(sram_addr), 32'd5);
        chk("rsthi.freeze", 32'(freeze), 32'd1);
        rst = 1'b0;
        #1;
        chk("rsthi.freeze_low", 32'(freeze), 32'd0);
        chk("rsthi.wb_low",     32'(WB_en), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rsthi.post.freeze", 32'(freeze), 32'd0);
        chk("rsthi.post.we_n",   32'(sram_we_n), 32'd1);
        chk("rsthi.post.rv",     MEM_read_value, 32'd0);
        chk("rsthi.post.addr",   32'(sram_addr), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        run_mem("rsthi.redo", 1'b0, 18'd4, 32'h1234_5678);

        // Store to the same address, then both enables set on 1035 -> read
        set_in(1'b0, 1'b0, 1'b1, 32'd1032, 32'hCAFE_F00D);
        run_mem("st2", 1'b1, 18'd4, 32'h1234_5678);
        set_in(1'b1, 1'b1, 1'b1, 32'd1035, 32'h5555_AAAA);
        run_mem("rw", 1'b0, 18'd4, 32'hCAFE_F00D);
        chk("rw.mem4", 32'(mem[4]), 32'hF00D);

`ifdef MEM_STAGE_READ_CACHE_EN
        // Repeat load of the cached index completes in IDLE
        set_in(1'b1, 1'b1, 1'b0, 32'd1032, 32'd0);
        @(negedge clk);
        chk("hit.freeze", 32'(freeze), 32'd0);
        chk("hit.wb",     32'(WB_en), 32'd1);
        chk("hit.rv",     MEM_read_value, 32'hCAFE_F00D);
        chk("hit.we_n",   32'(sram_we_n), 32'd1);
        chk("hit.oe",     32'(sram_dq_oe), 32'd0);
        step();
        // Any store invalidates, even to another word (2000 -> half-word 488)
        set_in(1'b0, 1'b0, 1'b1, 32'd2000, 32'h0BAD_0BAD);
        run_mem("inv.st", 1'b1, 18'd488, 32'hCAFE_F00D);
        set_in(1'b1, 1'b1, 1'b0, 32'd1032, 32'd0);
        run_mem("inv.ld", 1'b0, 18'd4, 32'hCAFE_F00D);
`else
        // Without the read tag a repeated load takes the full path again
        set_in(1'b1, 1'b1, 1'b0, 32'd1032, 32'd0);
        run_mem("again", 1'b0, 18'd4, 32'hCAFE_F00D);
`endif

        set_in(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
